// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request controller: issues word-aligned instruction bus requests, tracks
// outstanding responses and drops those made stale by a branch before they reach the FIFO.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                instr_req_o,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_gnt_i,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                busy_o
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1) + 1;

  typedef struct packed {
    logic valid;
    logic discard;
  } slot_t;

  slot_t [NUM_REQS-1:0] r_q;
  slot_t [NUM_REQS-1:0] w_q_nxt;
  logic  [29:0]         r_fetch_addr;
  logic                 r_req_pending;
  logic  [CW-1:0]       r_stray_cnt;

  logic [CW-1:0] w_out_cnt;
  logic [CW-1:0] w_busy_cnt;
  logic [CW-1:0] w_fifo_cnt;
  logic          w_room;
  logic          w_gnt;
  logic          w_pop;
  logic          w_push_done;
  logic [31:0]   w_branch_word;
  logic          w_unused;

  assign w_unused      = branch_addr_i[0];
  assign w_branch_word = {branch_addr_i[31:2], 2'b00};

  always_comb begin
    w_out_cnt  = '0;
    w_busy_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_out_cnt  += CW'(r_q[i].valid);
      w_busy_cnt += CW'(fifo_busy_i[i]);
    end
  end

  // A branch clears the FIFO this cycle, so its occupancy no longer limits fetching.
  assign w_fifo_cnt = branch_i ? '0 : w_busy_cnt;
  assign w_room     = (w_out_cnt + w_fifo_cnt) < CW'(NUM_REQS);

  assign instr_req_o  = r_req_pending | (req_i & w_room);
  assign instr_addr_o = branch_i ? w_branch_word : {r_fetch_addr, 2'b00};
  assign w_gnt        = instr_req_o & instr_gnt_i;
  assign w_pop        = instr_rvalid_i & r_q[0].valid;

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = {branch_addr_i[31:1], 1'b0};
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_valid_o = instr_rvalid_i & r_q[0].valid & ~r_q[0].discard & ~branch_i;
  assign busy_o       = r_req_pending | (w_out_cnt != '0);

  // Order within a cycle: pop oldest, mark survivors stale on branch, then push the grant.
  always_comb begin
    w_q_nxt     = r_q;
    w_push_done = 1'b0;
    if (w_pop) begin
      for (int i = 0; i < NUM_REQS - 1; i++) begin
        w_q_nxt[i] = r_q[i+1];
      end
      w_q_nxt[NUM_REQS-1] = '0;
    end
    if (branch_i) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        w_q_nxt[i].discard = w_q_nxt[i].discard | w_q_nxt[i].valid;
      end
    end
    if (w_gnt) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!w_q_nxt[i].valid && !w_push_done) begin
          w_q_nxt[i]  = '{valid: 1'b1, discard: 1'b0};
          w_push_done = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q           <= '0;
      r_req_pending <= 1'b0;
      r_fetch_addr  <= '0;
      // Responses still owed by the bus for requests dropped by this reset.
      r_stray_cnt   <= w_out_cnt + CW'(w_gnt);
    end else begin
      r_q           <= w_q_nxt;
      r_req_pending <= instr_req_o & ~instr_gnt_i;
      if (w_gnt) begin
        r_fetch_addr <= instr_addr_o[31:2] + 30'd1;
      end else if (branch_i) begin
        r_fetch_addr <= branch_addr_i[31:2];
      end
      if (instr_rvalid_i && !r_q[0].valid && r_stray_cnt != '0) begin
        r_stray_cnt <= r_stray_cnt - CW'(1);
      end
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i && instr_rvalid_i && !r_q[0].valid) begin
      assert (r_stray_cnt != '0);
    end
  end

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed bench for ibex_fetch_req_ctrl; FIFO pushes are checked by a scoreboard monitor.
module tb_ibex_fetch_req_ctrl;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, br, gnt, rv, er;
  logic [31:0]   ba, rd;
  logic [N-1:0]  fbusy;
  logic          instr_req_o, fifo_clear_o, fifo_valid_o, fifo_err_o, busy_o;
  logic [31:0]   instr_addr_o, fifo_addr_o, fifo_rdata_o;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [32:0]   exp_q[$];

  ibex_fetch_req_ctrl #(.NUM_REQS(N)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .branch_i(br), .branch_addr_i(ba),
    .fifo_busy_i(fbusy), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(gnt), .instr_rvalid_i(rv), .instr_rdata_i(rd), .instr_err_i(er),
    .fifo_clear_o(fifo_clear_o), .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o),
    .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r, input logic b, input logic [31:0] a, input logic g,
                     input logic v, input logic [31:0] d, input logic e);
    req = r; br = b; ba = a; gnt = g; rv = v; rd = d; er = e;
    #3;
  endtask

  task automatic exp_push(input logic [31:0] d, input logic e);
    exp_q.push_back({e, d});
  endtask

  // Monitor: every FIFO push must match the oldest expected response.
  logic [32:0] mon_exp;
  always @(negedge clk) begin
    if (fifo_valid_o) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: got data 0x%08h err %0b, expected no push",
                 fifo_rdata_o, fifo_err_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({fifo_err_o, fifo_rdata_o} !== mon_exp) begin
          n_fail++;
          $display("FAIL push_data: got err %0b data 0x%08h expected err %0b data 0x%08h",
                   fifo_err_o, fifo_rdata_o, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    fbusy = '0;
    rst   = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("rst_req", instr_req_o, 0);
    chk("rst_addr", instr_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_clear", fifo_clear_o, 0);
    chk("rst_fvalid", fifo_valid_o, 0);
    tick();

    // Streaming from 0x100, grant every cycle, response one cycle later.
    drv(1, 1, 32'h100, 1, 0, 0, 0);
    chk("s1_req0", instr_req_o, 1);
    chk("s1_addr0", instr_addr_o, 32'h100);
    chk("s1_clear0", fifo_clear_o, 1);
    tick();
    for (int k = 1; k <= 4; k++) begin
      d = 32'hD000_0000 + 32'(k - 1);
      exp_push(d, k == 3);
      drv(1, 0, 0, 1, 1, d, k == 3);
      chk("s1_req", instr_req_o, 1);
      chk("s1_addr", instr_addr_o, 32'h100 + 32'(4 * k));
      chk("s1_clear", fifo_clear_o, 0);
      tick();
    end
    exp_push(32'hD000_0004, 0);
    drv(0, 0, 0, 0, 1, 32'hD000_0004, 0);
    chk("s1_req_off", instr_req_o, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("s1_idle_busy", busy_o, 0);
    tick();

    // Unaligned branch target.
    drv(1, 1, 32'h202, 1, 0, 0, 0);
    chk("s2_addr", instr_addr_o, 32'h200);
    chk("s2_faddr", fifo_addr_o, 32'h202);
    tick();
    exp_push(32'hA5A5_0202, 0);
    drv(0, 0, 0, 0, 1, 32'hA5A5_0202, 0);
    tick();

    // Two outstanding, then branch to 0x80 with the queue full.
    drv(1, 1, 32'h10, 1, 0, 0, 0);
    chk("s3_addr10", instr_addr_o, 32'h10);
    tick();
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s3_addr14", instr_addr_o, 32'h14);
    tick();
    drv(1, 1, 32'h80, 1, 0, 0, 0);
    chk("s3_full_req", instr_req_o, 0);
    chk("s3_br_addr", instr_addr_o, 32'h80);
    tick();
    drv(1, 0, 0, 1, 1, 32'hBAD0_0010, 0);
    chk("s3_drop1", fifo_valid_o, 0);
    chk("s3_req_full", instr_req_o, 0);
    tick();
    drv(1, 0, 0, 1, 1, 32'hBAD0_0014, 0);
    chk("s3_drop2", fifo_valid_o, 0);
    chk("s3_req80", instr_req_o, 1);
    chk("s3_addr80", instr_addr_o, 32'h80);
    tick();
    exp_push(32'hD000_0080, 0);
    drv(0, 0, 0, 0, 1, 32'hD000_0080, 0);
    chk("s3_push80", fifo_valid_o, 1);
    tick();

    // Held request: gnt low for 3 cycles, req_i drops, branch to 0x40 meanwhile.
    drv(1, 0, 0, 0, 0, 0, 0);
    chk("s4_req_a", instr_req_o, 1);
    chk("s4_addr_a", instr_addr_o, 32'h84);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("s4_req_b", instr_req_o, 1);
    chk("s4_addr_b", instr_addr_o, 32'h84);
    tick();
    drv(0, 1, 32'h40, 0, 0, 0, 0);
    chk("s4_req_c", instr_req_o, 1);
    chk("s4_addr_c", instr_addr_o, 32'h40);
    tick();
    drv(0, 0, 0, 1, 0, 0, 0);
    chk("s4_req_d", instr_req_o, 1);
    chk("s4_addr_d", instr_addr_o, 32'h40);
    tick();
    exp_push(32'hD000_0040, 0);
    drv(0, 0, 0, 0, 1, 32'hD000_0040, 0);
    chk("s4_busy", busy_o, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("s4_idle_busy", busy_o, 0);
    chk("s4_idle_req", instr_req_o, 0);
    tick();

    // FIFO occupancy limits outstanding requests.
    fbusy = 2'b01;
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s5_addr44", instr_addr_o, 32'h44);
    chk("s5_req1", instr_req_o, 1);
    tick();
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s5_block1", instr_req_o, 0);
    tick();
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s5_block2", instr_req_o, 0);
    tick();
    exp_push(32'hD000_0044, 0);
    drv(1, 0, 0, 1, 1, 32'hD000_0044, 0);
    chk("s5_block_rsp", instr_req_o, 0);
    tick();
    fbusy = 2'b00;
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s5_addr48", instr_addr_o, 32'h48);
    tick();
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s5_addr4c", instr_addr_o, 32'h4C);
    chk("s5_req2", instr_req_o, 1);
    tick();
    exp_push(32'hD000_0048, 0);
    drv(1, 0, 0, 1, 1, 32'hD000_0048, 0);
    chk("s5_full", instr_req_o, 0);
    tick();
    exp_push(32'hD000_004C, 1);
    drv(0, 0, 0, 0, 1, 32'hD000_004C, 1);
    tick();

    // Grant, response and branch in the same cycle.
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s6_addr50", instr_addr_o, 32'h50);
    tick();
    drv(1, 1, 32'h300, 1, 1, 32'hBAD0_0050, 0);
    chk("s6_drop_br", fifo_valid_o, 0);
    chk("s6_addr300", instr_addr_o, 32'h300);
    chk("s6_req", instr_req_o, 1);
    tick();
    exp_push(32'hD000_0300, 0);
    drv(0, 0, 0, 0, 1, 32'hD000_0300, 0);
    chk("s6_push300", fifo_valid_o, 1);
    tick();

    // Address wrap at the top of memory.
    drv(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    chk("s7_addr_top", instr_addr_o, 32'hFFFF_FFFC);
    tick();
    exp_push(32'hD000_00FC, 0);
    drv(1, 0, 0, 0, 1, 32'hD000_00FC, 0);
    chk("s7_wrap_req", instr_req_o, 1);
    chk("s7_wrap_addr", instr_addr_o, 32'h0);
    tick();
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s7_wrap_hold", instr_addr_o, 32'h0);
    tick();
    exp_push(32'hD000_0000, 0);
    drv(0, 0, 0, 0, 1, 32'hD000_0000, 0);
    tick();

    // Reset with two outstanding; late responses must be ignored.
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s8_addr4", instr_addr_o, 32'h4);
    tick();
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("s8_addr8", instr_addr_o, 32'h8);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("s8_busy_pre", busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("s8_busy_post", busy_o, 0);
    chk("s8_req_post", instr_req_o, 0);
    chk("s8_addr_post", instr_addr_o, 0);
    tick();
    drv(0, 0, 0, 0, 1, 32'hBAD0_0001, 0);
    chk("s8_stray1", fifo_valid_o, 0);
    tick();
    drv(0, 0, 0, 0, 1, 32'hBAD0_0002, 0);
    chk("s8_stray2", fifo_valid_o, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
